// File: rtl/timer_dev.sv
// ---------------------------------------------------------------------------
// timer_dev
//   Memory-mapped countdown timer feeding CP0 HWInt[2]. Software programs it
//   through the system bridge with word accesses at offsets 0x0/0x4/0x8.
//   A four-state FSM (IDLE/LOAD/CNT/INT) loads PRESET into COUNT, counts
//   down to zero and raises an interrupt either once (mode 0) or
//   periodically with auto-reload (mode 1).
//
//   Register map (addr[3:2]):
//     0x0 CTRL   [0] EN, [2:1] MODE (01 periodic, else one-shot), [3] IM
//     0x4 PRESET read/write reload value
//     0x8 COUNT  read-only current count
//     0xC        reads 0, writes ignored
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   addr   in   [31:0] byte address; hit when addr[31:4] == BASE_ADDR[31:4]
//   we     in   write strobe, effective only on an address hit
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] combinational read data selected by addr[3:2]
//   irq    out  interrupt request (irq_flag gated by CTRL.IM)
// ---------------------------------------------------------------------------
module timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state, state_nx;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count, count_nx;
    logic        irq_flag;

    logic        hit;
    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;

    logic        flag_set;
    logic        flag_clr_fsm;
    logic        en_clr;

    // Byte-lane bits are irrelevant for word-only register accesses.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel       = addr[3:2];
    assign wr_ctrl   = we && hit && (sel == 2'd0);
    assign wr_preset = we && hit && (sel == 2'd1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath controls. EN and MODE are taken from the
    // registered CTRL, so a write on this edge is only seen on the next one.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        count_nx     = count;
        flag_set     = 1'b0;
        flag_clr_fsm = 1'b0;
        en_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                count_nx = preset;
                state_nx = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_nx = IDLE;
                end else if (count > 32'd1) begin
                    count_nx = count - 32'd1;
                end else begin
                    // Covers COUNT == 0 (PRESET of 0) so COUNT never wraps.
                    count_nx = '0;
                    flag_set = 1'b1;
                    state_nx = INT;
                end
            end
            INT: begin
                if (ctrl_mode == 2'b01) begin
                    flag_clr_fsm = 1'b1;
                    state_nx     = LOAD;
                end else begin
                    en_clr   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // CTRL register: a software write beats the one-shot EN auto-clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= wdata[0];
            ctrl_mode <= wdata[2:1];
            ctrl_im   <= wdata[3];
        end else if (en_clr) begin
            ctrl_en   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // PRESET register; COUNT picks up a new value only at the next LOAD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            preset <= '0;
        end else if (wr_preset) begin
            preset <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // COUNT register (changes only through LOAD and CNT)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_nx;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt flag: the FSM set has priority over any clear, including
    // the clear caused by a software write to CTRL or PRESET.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (flag_set) begin
            irq_flag <= 1'b1;
        end else if (wr_ctrl || wr_preset || flag_clr_fsm) begin
            irq_flag <= 1'b0;
        end
    end

    assign irq = irq_flag & ctrl_im;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (sel)
            2'd0:    rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

    localparam logic [31:0] TB_BASE = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int unsigned total;
    int unsigned bad;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    timer_dev #(.BASE_ADDR(TB_BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Write lands on the next clock edge; returns 1ns after that edge.
    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        addr  = TB_BASE + {28'd0, off};
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard observed=%h expected=<empty queue>", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.val);
            end
        end
    endtask

    task automatic rd_chk(input logic [3:0] off, input logic [31:0] e, input string tag);
        addr = TB_BASE + {28'd0, off};
        sb.push_back('{tag, e});
        #1;
        compare(rdata);
    endtask

    task automatic irq_chk(input logic e, input string tag);
        sb.push_back('{tag, {31'd0, e}});
        compare({31'd0, irq});
    endtask

    initial begin
        logic        e_irq;
        logic [31:0] e_cnt;
        int          m;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        addr  = '0;
        we    = 1'b0;
        wdata = '0;

        // Reset state
        ticks(2);
        reset = 1'b0;
        irq_chk(1'b0, "rst_irq");
        rd_chk(4'h0, 32'd0, "rst_ctrl");
        rd_chk(4'h4, 32'd0, "rst_preset");
        rd_chk(4'h8, 32'd0, "rst_count");
        rd_chk(4'hC, 32'd0, "rst_offC");

        // One-shot, PRESET = 3
        wr(4'h4, 32'd3);
        wr(4'h0, 32'h9);            // edge E
        tick();                     // E+1
        tick();                     // E+2
        rd_chk(4'h8, 32'd3, "os_cnt_e2");
        tick();
        rd_chk(4'h8, 32'd2, "os_cnt_e3");
        tick();
        rd_chk(4'h8, 32'd1, "os_cnt_e4");
        irq_chk(1'b0, "os_irq_e4");
        tick();
        rd_chk(4'h8, 32'd0, "os_cnt_e5");
        irq_chk(1'b1, "os_irq_e5");
        ticks(2);
        irq_chk(1'b1, "os_irq_hold");
        rd_chk(4'h0, 32'h8, "os_ctrl_en_clr");
        rd_chk(4'h8, 32'd0, "os_cnt_hold");
        wr(4'h0, 32'h8);
        irq_chk(1'b0, "os_irq_cleared");

        // Periodic, PRESET = 4: pulses at E+6, E+12, ... one cycle wide
        wr(4'h4, 32'd4);
        wr(4'h0, 32'hB);            // edge E
        for (int k = 1; k <= 32; k++) begin
            tick();
            e_irq = (k >= 6) && ((k % 6) == 0);
            irq_chk(e_irq, "per_irq");
        end
        wr(4'h0, 32'h0);
        ticks(3);

        // Masked periodic, PRESET = 2: COUNT cycles 2,1,0,0 with irq held low
        wr(4'h4, 32'd2);
        wr(4'h0, 32'h3);            // edge E
        tick();
        for (int k = 2; k <= 12; k++) begin
            tick();
            m = (k - 2) % 4;
            e_cnt = (m == 0) ? 32'd2 : (m == 1) ? 32'd1 : 32'd0;
            rd_chk(4'h8, e_cnt, "mask_cnt");
            irq_chk(1'b0, "mask_irq");
        end
        wr(4'h0, 32'h0);
        ticks(3);

        // IM written on the same edge the flag is set: the set wins
        wr(4'h4, 32'd3);
        wr(4'h0, 32'h1);            // edge E
        ticks(4);                   // E+4
        wr(4'h0, 32'h9);            // edge E+5
        irq_chk(1'b1, "im_same_edge");
        tick();
        irq_chk(1'b1, "im_hold");
        rd_chk(4'h0, 32'h8, "im_ctrl");
        wr(4'h0, 32'h8);
        irq_chk(1'b0, "im_cleared");

        // Disable mid-count, PRESET = 10
        wr(4'h4, 32'd10);
        wr(4'h0, 32'h1);            // edge E
        ticks(5);                   // E+5
        rd_chk(4'h8, 32'd7, "dis_cnt_e5");
        wr(4'h0, 32'h0);            // edge E+6 -> COUNT 6, EN 0
        rd_chk(4'h8, 32'd6, "dis_cnt_e6");
        ticks(4);
        rd_chk(4'h8, 32'd6, "dis_frozen");
        irq_chk(1'b0, "dis_irq");

        // Ignored writes: COUNT, offset 0xC, and an address miss
        wr(4'h8, 32'h0000_1234);
        rd_chk(4'h8, 32'd6, "ro_count");
        wr(4'hC, 32'hFFFF_FFFF);
        rd_chk(4'hC, 32'd0, "ro_offC");
        addr  = 32'h0000_7E04;
        wdata = 32'hDEAD_BEEF;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        rd_chk(4'h4, 32'd10, "miss_preset");
        wr(4'h0, 32'hFFFF_FFF1);
        rd_chk(4'h0, 32'h1, "ctrl_upper_ignored");
        tick();                     // LOAD
        tick();
        rd_chk(4'h8, 32'd10, "reenable_reload");
        wr(4'h0, 32'h0);
        ticks(3);

        // PRESET = 0 one-shot: flag after E+3
        wr(4'h4, 32'd0);
        wr(4'h0, 32'h9);            // edge E
        ticks(2);
        irq_chk(1'b0, "p0_irq_e2");
        tick();
        irq_chk(1'b1, "p0_irq_e3");
        rd_chk(4'h8, 32'd0, "p0_cnt");
        wr(4'h0, 32'h8);
        irq_chk(1'b0, "p0_cleared");
        ticks(2);

        // Reset at COUNT = 2
        wr(4'h4, 32'd5);
        wr(4'h0, 32'h9);            // edge E
        ticks(5);                   // E+5
        rd_chk(4'h8, 32'd2, "rst_mid_cnt2");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk(4'h0, 32'd0, "rst_mid_ctrl");
        rd_chk(4'h4, 32'd0, "rst_mid_preset");
        rd_chk(4'h8, 32'd0, "rst_mid_count");
        for (int k = 0; k < 10; k++) begin
            irq_chk(1'b0, "rst_mid_irq");
            tick();
        end

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
